// File: rtl/gpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// gpu_sequencer_if -- signal bundle around the GPU command sequencer.
//
// Groups:
//   s1_*          host register slave port (address, read/write strobes,
//                 write data, combinational read data, waitrequest) + irq
//   m1_*          pixel write master (address, data, write, waitrequest)
//   op_*          shader-array command channel (start pulse, opcode, argument,
//                 done/error completion)
//   pixel_index / pixel_in   combinational pixel fetch from the shader array
//
// Modports:
//   slave  -- the sequencer's view (it is the slave on the host port)
//   master -- the surrounding system's view (host, memory, shader array)
//
// PIXEL_BITS and NUM_SHADERS must match the values given to gpu_sequencer.
// -----------------------------------------------------------------------------
interface gpu_sequencer_if #(
    parameter int PIXEL_BITS  = 16,
    parameter int NUM_SHADERS = 320
);
    localparam int IDX_W = $clog2(NUM_SHADERS);

    // host register port
    logic [7:0]            s1_address;
    logic                  s1_read;
    logic                  s1_write;
    logic [31:0]           s1_writedata;
    logic [31:0]           s1_readdata;
    logic                  s1_waitrequest;
    logic                  irq;

    // pixel write master
    logic [31:0]           m1_address;
    logic [PIXEL_BITS-1:0] m1_writedata;
    logic                  m1_write;
    logic                  m1_waitrequest;

    // shader-array command channel
    logic                  op_start;
    logic [1:0]            op_code;
    logic [31:0]           op_arg;
    logic                  op_done;
    logic                  op_error;

    // pixel fetch
    logic [IDX_W-1:0]      pixel_index;
    logic [PIXEL_BITS-1:0] pixel_in;

    modport slave (
        input  s1_address, s1_read, s1_write, s1_writedata,
        output s1_readdata, s1_waitrequest, irq,
        output m1_address, m1_writedata, m1_write,
        input  m1_waitrequest,
        output op_start, op_code, op_arg,
        input  op_done, op_error,
        output pixel_index,
        input  pixel_in
    );

    modport master (
        output s1_address, s1_read, s1_write, s1_writedata,
        input  s1_readdata, s1_waitrequest, irq,
        input  m1_address, m1_writedata, m1_write,
        output m1_waitrequest,
        input  op_start, op_code, op_arg,
        output op_done, op_error,
        input  pixel_index,
        output pixel_in
    );
endinterface

// File: rtl/gpu_sequencer.sv
// -----------------------------------------------------------------------------
// gpu_sequencer -- host-programmed command sequencer for a shader array.
//
// The host writes commands to registers 0x00-0x03 (opcode = low address bits,
// argument = write data); they queue in a CMD_DEPTH-entry FIFO. Opcode 2 is a
// pixel write-out burst of NUM_SHADERS words to memory starting at the
// argument address (2-byte stride); every other opcode is handed to the shader
// array as a one-cycle op_start pulse and waits for op_done / op_error.
//
// Register map (host port):
//   0x00-0x03  W   push command {opcode = address[1:0], arg = writedata}
//   0x0d       R/W busy-cycle counter (only with GPU_PERF_COUNTER_EN; any
//                  write clears it), otherwise reads 0
//   0x0e       R/W bit0 irq_en
//   0x0f       R   bit0 busy, bit1 error, bit2 irq_pend, [15:8] FIFO count;
//                  a read clears irq_pend
//              W   bit0=1 while in ERROR returns to IDLE
//
// Ports:
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      gpu_sequencer_if.slave (host port, pixel master, shader command
//            channel, pixel fetch, irq)
//
// Optional feature macro: GPU_PERF_COUNTER_EN (busy-cycle counter at 0x0d).
// -----------------------------------------------------------------------------
module gpu_sequencer #(
    parameter int PIXEL_BITS  = 16,
    parameter int NUM_SHADERS = 320,
    parameter int CMD_DEPTH   = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    gpu_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SHADERS);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] ADDR_PERF = 8'h0d;
    localparam logic [7:0] ADDR_CTRL = 8'h0e;
    localparam logic [7:0] ADDR_STAT = 8'h0f;
    localparam logic [1:0] OP_BURST  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BURST,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] arg;
    } cmd_t;

    state_t                state, state_next;
    cmd_t                  fifo_mem [CMD_DEPTH];
    cmd_t                  head;
    cmd_t                  in_cmd;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count, count_next;
    logic [1:0]            cur_op;
    logic [31:0]           cur_arg;
    logic [IDX_W-1:0]      index;
    logic                  irq_en, irq_pend;
    logic [31:0]           perf_rd;
    logic [PIXEL_BITS-1:0] pix_out;

    logic cmd_addr, fifo_full, fifo_empty;
    logic push, pop, flush, clear_err;
    logic beat_accept, last_beat, retire, irq_set, irq_clr;
    logic in_issue, in_burst, in_error, busy;

    // ------------------------------------------------------------ decode
    assign cmd_addr   = (bus.s1_address[7:2] == 6'd0);
    assign fifo_full  = (count == CNT_W'(CMD_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign in_cmd     = '{op: bus.s1_address[1:0], arg: bus.s1_writedata};

    // Command writes are silently dropped in ERROR, so they never stall there.
    assign push      = bus.s1_write && cmd_addr && !in_error && !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign flush     = (state == S_WAIT) && bus.op_error;
    assign clear_err = in_error && bus.s1_write && (bus.s1_address == ADDR_STAT)
                       && bus.s1_writedata[0];

    assign beat_accept = in_burst && !bus.m1_waitrequest;
    assign last_beat   = (index == IDX_W'(NUM_SHADERS - 1));
    assign retire      = ((state == S_WAIT) && bus.op_done && !bus.op_error)
                         || (beat_accept && last_beat);

    // A retire never coincides with a pop (pops happen only in IDLE), so the
    // post-edge count tells whether the queue is drained.
    assign irq_set = (retire && (count_next == '0)) || flush;
    assign irq_clr = bus.s1_read && (bus.s1_address == ADDR_STAT);

    // ------------------------------------------------------------ FSM
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers see pre-edge values regardless of evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: each combinational block assigns defaults first so no path
    // leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!fifo_empty)
                         state_next = (head.op == OP_BURST) ? S_BURST : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (bus.op_error)     state_next = S_ERROR;
                     else if (bus.op_done) state_next = S_IDLE;
            S_BURST: if (beat_accept && last_beat) state_next = S_IDLE;
            S_ERROR: if (clear_err) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_issue = 1'b0;
        in_burst = 1'b0;
        in_error = 1'b0;
        case (state)
            S_ISSUE: in_issue = 1'b1;
            S_BURST: in_burst = 1'b1;
            S_ERROR: in_error = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

    // ------------------------------------------------------------ FIFO
    always_comb begin
        count_next = count;
        if (flush)              count_next = '0;
        else if (push && !pop)  count_next = count + CNT_W'(1);
        else if (pop && !push)  count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; the count/pointers guarding it
    // do, so stale entries are never observed.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= in_cmd;
    end

    // ------------------------------------------------------------ datapath
    // cur_op/cur_arg hold the popped command until the next pop, keeping
    // op_code/op_arg stable for the whole life of a command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_op  <= '0;
            cur_arg <= '0;
            index   <= '0;
        end else begin
            if (pop) begin
                cur_op  <= head.op;
                cur_arg <= head.arg;
            end
            if (beat_accept) index <= last_beat ? '0 : index + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            if (bus.s1_write && (bus.s1_address == ADDR_CTRL))
                irq_en <= bus.s1_writedata[0];
            if (irq_set)      irq_pend <= 1'b1;
            else if (irq_clr) irq_pend <= 1'b0;
        end
    end

`ifdef GPU_PERF_COUNTER_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            perf_cnt <= '0;
        else if (bus.s1_write && (bus.s1_address == ADDR_PERF))
            perf_cnt <= '0;
        else if (busy && (perf_cnt != '1))
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_rd = perf_cnt;
`else
    assign perf_rd = '0;
`endif

    // ------------------------------------------------------------ outputs
    assign pix_out = in_burst ? bus.pixel_in : '0;

    assign bus.op_start       = in_issue;
    assign bus.op_code        = cur_op;
    assign bus.op_arg         = cur_arg;
    assign bus.m1_write       = in_burst;
    assign bus.m1_address     = in_burst ? (cur_arg + (32'(index) << 1)) : 32'd0;
    assign bus.m1_writedata   = pix_out;
    assign bus.pixel_index    = index;
    assign bus.s1_waitrequest = bus.s1_write && cmd_addr && !in_error && fifo_full;
    assign bus.irq            = irq_pend && irq_en;

    always_comb begin
        bus.s1_readdata = '0;
        case (bus.s1_address)
            ADDR_PERF: bus.s1_readdata = perf_rd;
            ADDR_CTRL: bus.s1_readdata[0] = irq_en;
            ADDR_STAT: begin
                bus.s1_readdata[0]    = busy;
                bus.s1_readdata[1]    = in_error;
                bus.s1_readdata[2]    = irq_pend;
                bus.s1_readdata[15:8] = 8'(count);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_gpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gpu_sequencer -- self-checking bench for gpu_sequencer
// (NUM_SHADERS=4, CMD_DEPTH=4, PIXEL_BITS=16).
// Inputs change on the falling edge; outputs are compared 1 time unit later,
// the rising edge in between consumes the inputs.
// -----------------------------------------------------------------------------
module tb_gpu_sequencer;
    localparam int PIXEL_BITS  = 16;
    localparam int NUM_SHADERS = 4;
    localparam int CMD_DEPTH   = 4;
`ifdef GPU_PERF_COUNTER_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    gpu_sequencer_if #(.PIXEL_BITS(PIXEL_BITS), .NUM_SHADERS(NUM_SHADERS)) bus ();

    gpu_sequencer #(
        .PIXEL_BITS (PIXEL_BITS),
        .NUM_SHADERS(NUM_SHADERS),
        .CMD_DEPTH  (CMD_DEPTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic host(input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [31:0] wdata);
        bus.s1_write     = wr;
        bus.s1_read      = rd;
        bus.s1_address   = addr;
        bus.s1_writedata = wdata;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_irq"},      bus.irq, 0);
        check({tag, "_op_start"}, bus.op_start, 0);
        check({tag, "_op_code"},  bus.op_code, 0);
        check({tag, "_op_arg"},   bus.op_arg, 0);
        check({tag, "_m1_write"}, bus.m1_write, 0);
        check({tag, "_m1_addr"},  bus.m1_address, 0);
        check({tag, "_m1_wdata"}, bus.m1_writedata, 0);
        check({tag, "_pix_idx"},  bus.pixel_index, 0);
        check({tag, "_s1_wait"},  bus.s1_waitrequest, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        host(0, 0, 8'h00, 0);
        bus.op_done = 0; bus.op_error = 0; bus.m1_waitrequest = 0; bus.pixel_in = '0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------ reference model
    typedef struct {
        logic [1:0]  op;
        logic [31:0] arg;
    } cmd_t;

    cmd_t        cq[$];       // queued commands, oldest first
    bit          m_act;       // a command has been taken from the queue
    bit          m_started;   // its op_start pulse has been given
    bit          m_err;
    logic [1:0]  m_op;
    logic [31:0] m_arg;
    int          m_beat;      // accepted burst writes so far
    bit          m_en, m_pend;
    logic [31:0] m_perf;

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        logic [31:0] r;
        bit          busy;
        r    = 0;
        busy = m_act || m_err || (cq.size() != 0);
        case (a)
            8'h0d: r = PERF_EN ? m_perf : 32'd0;
            8'h0e: r = {31'd0, m_en};
            8'h0f: r = {16'd0, 8'(cq.size()), 5'd0, m_pend, m_err, busy};
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic run_random(input int ncyc);
        cmd_t        e;
        bit          wr, rd, push, retire, set_p, busy, burst;
        logic [7:0]  a;
        logic [31:0] wd, exp_addr;
        int          r;
        cq.delete();
        m_act = 0; m_started = 0; m_err = 0; m_op = 0; m_arg = 0; m_beat = 0;
        m_en = 0; m_pend = 0; m_perf = 0;
        for (int n = 0; n < ncyc; n++) begin
            r  = $urandom_range(0, 99);
            wr = (r < 35);
            rd = (r >= 35) && (r < 55);
            r  = $urandom_range(0, 99);
            if (r < 55)      a = 8'($urandom_range(0, 3));
            else if (r < 65) a = 8'h0e;
            else if (r < 82) a = 8'h0f;
            else if (r < 87) a = 8'h0d;
            else             a = 8'($urandom_range(0, 255));
            wd = $urandom();
            host(wr, rd, a, wd);
            bus.op_done        = ($urandom_range(0, 99) < 20);
            bus.op_error       = ($urandom_range(0, 99) < 3);
            bus.m1_waitrequest = ($urandom_range(0, 99) < 40);
            bus.pixel_in       = 16'($urandom());
            #1;

            busy     = m_act || m_err || (cq.size() != 0);
            burst    = m_act && (m_op == 2'd2);
            exp_addr = burst ? m_arg + 32'(2 * m_beat) : 32'd0;
            check("rnd_s1_wait", bus.s1_waitrequest,
                  32'(wr && (a < 8'd4) && !m_err && (cq.size() == CMD_DEPTH)));
            check("rnd_op_start", bus.op_start, 32'(m_act && !burst && !m_started));
            check("rnd_m1_write", bus.m1_write, 32'(burst));
            check("rnd_m1_addr",  bus.m1_address, exp_addr);
            check("rnd_pix_idx",  bus.pixel_index, burst ? 32'(m_beat) : 32'd0);
            check("rnd_m1_wdata", bus.m1_writedata, burst ? 32'(bus.pixel_in) : 32'd0);
            check("rnd_rdata",    bus.s1_readdata, model_rd(a));
            check("rnd_irq",      bus.irq, 32'(m_pend && m_en));
            if (m_act) begin
                check("rnd_op_code", bus.op_code, 32'(m_op));
                check("rnd_op_arg",  bus.op_arg, m_arg);
            end

            // consequences of the coming rising edge
            push   = wr && (a < 8'd4) && !m_err && (cq.size() < CMD_DEPTH);
            retire = 0;
            set_p  = 0;
            if (m_err) begin
                if (wr && (a == 8'h0f) && wd[0]) m_err = 0;
            end else if (!m_act) begin
                if (cq.size() != 0) begin
                    e = cq.pop_front();
                    m_act = 1; m_started = 0; m_beat = 0; m_op = e.op; m_arg = e.arg;
                end
            end else if (!burst && !m_started) begin
                m_started = 1;
            end else if (!burst) begin
                if (bus.op_error) begin
                    m_err = 1; m_act = 0; cq.delete(); push = 0; set_p = 1;
                end else if (bus.op_done) begin
                    m_act = 0; retire = 1;
                end
            end else if (!bus.m1_waitrequest) begin
                if (m_beat == NUM_SHADERS - 1) begin m_act = 0; retire = 1; end
                else m_beat++;
            end
            if (push) begin
                e.op = a[1:0]; e.arg = wd;
                cq.push_back(e);
            end
            if (retire && cq.size() == 0) set_p = 1;
            if (set_p)                          m_pend = 1;
            else if (rd && (a == 8'h0f))        m_pend = 0;
            if (wr && (a == 8'h0e))             m_en = wd[0];
            if (wr && (a == 8'h0d))             m_perf = 0;
            else if (busy && m_perf != '1)      m_perf = m_perf + 1;
            step();
        end
        host(0, 0, 8'h00, 0);
        bus.op_done = 0; bus.op_error = 0; bus.m1_waitrequest = 0;
    endtask

    // ------------------------------------------------------------ register vectors
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;   // read data seen before the edge
    } reg_vec_t;

    reg_vec_t vec [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{wr: 0, rd: 1, addr: 8'h0e, wdata: 32'h0,        exp_rd: 32'h0};
        vec[1]  = '{wr: 1, rd: 0, addr: 8'h0e, wdata: 32'h1,        exp_rd: 32'h0};
        vec[2]  = '{wr: 0, rd: 1, addr: 8'h0e, wdata: 32'h0,        exp_rd: 32'h1};
        vec[3]  = '{wr: 0, rd: 1, addr: 8'h0f, wdata: 32'h0,        exp_rd: 32'h0};
        vec[4]  = '{wr: 0, rd: 1, addr: 8'h0d, wdata: 32'h0,        exp_rd: 32'h0};
        vec[5]  = '{wr: 0, rd: 1, addr: 8'h10, wdata: 32'h0,        exp_rd: 32'h0};
        vec[6]  = '{wr: 0, rd: 1, addr: 8'h00, wdata: 32'h0,        exp_rd: 32'h0};
        vec[7]  = '{wr: 1, rd: 0, addr: 8'h0f, wdata: 32'h1,        exp_rd: 32'h0};
        vec[8]  = '{wr: 0, rd: 1, addr: 8'h0f, wdata: 32'h0,        exp_rd: 32'h0};
        vec[9]  = '{wr: 1, rd: 0, addr: 8'h0e, wdata: 32'hFFFFFFFE, exp_rd: 32'h1};
        vec[10] = '{wr: 0, rd: 1, addr: 8'h0e, wdata: 32'h0,        exp_rd: 32'h0};
        vec[11] = '{wr: 0, rd: 1, addr: 8'hff, wdata: 32'h0,        exp_rd: 32'h0};

        // reset state
        host(0, 0, 8'h00, 0);
        bus.op_done = 0; bus.op_error = 0; bus.m1_waitrequest = 0; bus.pixel_in = '0;
        step();
        #1;
        check_quiet_outputs("rst");
        do_reset();
        host(0, 0, 8'h0f, 0); #1;
        check("rst_status", bus.s1_readdata, 0);

        // register map vectors
        for (int i = 0; i < 12; i++) begin
            host(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wdata);
            #1;
            check($sformatf("vec%0d_rdata", i), bus.s1_readdata, vec[i].exp_rd);
            check($sformatf("vec%0d_wait", i), bus.s1_waitrequest, 0);
            check($sformatf("vec%0d_irq", i), bus.irq, 0);
            step();
        end

        // single shader command, interrupt, busy-cycle count
        host(1, 0, 8'h0e, 32'h1); step();
        host(1, 0, 8'h0d, 32'h0); step();
        host(1, 0, 8'h01, 32'h5); #1;
        check("cmd_push_wait", bus.s1_waitrequest, 0);
        step();
        host(0, 0, 8'h0f, 0); #1;
        check("cmd_queued_status", bus.s1_readdata, 32'h101);
        check("cmd_no_start_yet", bus.op_start, 0);
        step(); #1;
        check("cmd_op_start", bus.op_start, 1);
        check("cmd_op_code", bus.op_code, 1);
        check("cmd_op_arg", bus.op_arg, 5);
        step(); #1;
        check("cmd_start_once", bus.op_start, 0);
        check("cmd_code_stable", bus.op_code, 1);
        check("cmd_arg_stable", bus.op_arg, 5);
        step(); step();
        bus.op_done = 1; #1;
        check("cmd_irq_before_done", bus.irq, 0);
        step();
        bus.op_done = 0; #1;
        check("cmd_irq", bus.irq, 1);
        check("cmd_status_pend", bus.s1_readdata, 32'h4);
        host(0, 1, 8'h0f, 0); step();
        host(0, 0, 8'h0d, 0); #1;
        check("cmd_irq_cleared", bus.irq, 0);
        check("cmd_perf", bus.s1_readdata, PERF_EN ? 32'd5 : 32'd0);
        host(0, 0, 8'h0f, 0); #1;
        check("cmd_status_idle", bus.s1_readdata, 0);

        // write-out burst with alternating backpressure
        host(1, 0, 8'h02, 32'h1000); step();
        host(0, 0, 8'h0f, 0); step();
        for (int c = 0; c < 8; c++) begin
            bus.m1_waitrequest = (c % 2 == 0);
            bus.pixel_in       = 16'(16'hA000 + c);
            #1;
            check($sformatf("bst%0d_write", c), bus.m1_write, 1);
            check($sformatf("bst%0d_addr", c), bus.m1_address, 32'h1000 + 32'(2 * (c / 2)));
            check($sformatf("bst%0d_pidx", c), bus.pixel_index, 32'(c / 2));
            check($sformatf("bst%0d_wdata", c), bus.m1_writedata, 32'hA000 + 32'(c));
            step();
        end
        bus.m1_waitrequest = 0; #1;
        check("bst_done_write", bus.m1_write, 0);
        check("bst_done_status", bus.s1_readdata, 32'h4);
        check("bst_done_irq", bus.irq, 1);
        host(0, 1, 8'h0f, 0); step();
        host(0, 0, 8'h00, 0);

        // FIFO fill with a stalled shader command
        do_reset();
        for (int k = 0; k < 5; k++) begin
            host(1, 0, (k % 2 == 1) ? 8'h01 : 8'h03, 32'h100 + 32'(k)); #1;
            check($sformatf("fill_push%0d_wait", k + 1), bus.s1_waitrequest, 0);
            step();
        end
        host(1, 0, 8'h00, 32'h200);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("fill_push6_wait%0d", k), bus.s1_waitrequest, 1);
            step();
        end
        bus.op_done = 1; #1;
        check("fill_done_wait", bus.s1_waitrequest, 1);
        check("fill_first_code", bus.op_code, 3);
        check("fill_first_arg", bus.op_arg, 32'h100);
        step();
        bus.op_done = 0; #1;
        check("fill_idle_full_wait", bus.s1_waitrequest, 1);
        step(); #1;
        check("fill_freed_wait", bus.s1_waitrequest, 0);
        check("fill_second_code", bus.op_code, 1);
        check("fill_second_arg", bus.op_arg, 32'h101);
        step();
        host(0, 0, 8'h0f, 0); #1;
        check("fill_status", bus.s1_readdata, 32'h401);

        // error with queued work, then recovery
        do_reset();
        for (int k = 0; k < 3; k++) begin
            host(1, 0, 8'h01, 32'h300 + 32'(k)); step();
        end
        host(0, 0, 8'h0f, 0); #1;
        check("err_pre_status", bus.s1_readdata, 32'h201);
        bus.op_done = 1; bus.op_error = 1;
        step();
        bus.op_done = 0; bus.op_error = 0; #1;
        check("err_status", bus.s1_readdata, 32'h7);
        check("err_irq_gated", bus.irq, 0);
        host(1, 0, 8'h00, 32'h55); #1;
        check("err_push_wait", bus.s1_waitrequest, 0);
        step();
        host(1, 0, 8'h0f, 32'h0); step();
        host(0, 0, 8'h0f, 0); #1;
        check("err_stays", bus.s1_readdata, 32'h7);
        host(1, 0, 8'h0f, 32'h1); step();
        host(0, 0, 8'h0f, 0); #1;
        check("err_cleared_status", bus.s1_readdata, 32'h4);
        step(); #1;
        check("err_flushed_start", bus.op_start, 0);
        check("err_flushed_status", bus.s1_readdata, 32'h4);

        // reset in the middle of a burst whose addresses wrap
        do_reset();
        host(1, 0, 8'h02, 32'hFFFF_FFFC); step();
        host(0, 0, 8'h0f, 0); step(); #1;
        check("rb_addr0", bus.m1_address, 32'hFFFF_FFFC);
        step(); #1;
        check("rb_addr1", bus.m1_address, 32'hFFFF_FFFE);
        step(); #1;
        check("rb_addr2_wrap", bus.m1_address, 32'h0);
        check("rb_pidx2", bus.pixel_index, 2);
        reset_n = 1'b0; #1;
        check("rb_abort_write", bus.m1_write, 0);
        step(); #1;
        check_quiet_outputs("rb_in_reset");
        reset_n = 1'b1;
        step(); #1;
        check("rb_status", bus.s1_readdata, 0);
        check("rb_no_write", bus.m1_write, 0);
        step(); #1;
        check("rb_no_start", bus.op_start, 0);
        check("rb_still_no_write", bus.m1_write, 0);

        // randomized traffic against the reference model
        do_reset();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpu_sequencer.md
GPU_SEQUENCER -- requirements
Module: gpu_sequencer

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 16: width of one pixel word.
REQ-002 SHALL have parameter NUM_SHADERS, default 320: pixels per write-out burst.
REQ-003 SHALL have parameter CMD_DEPTH, default 4: command FIFO entries (power of two, ≥2).
REQ-004 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port s1_address  in  8  register address.
REQ-007 SHALL have ports s1_read and s1_write  in  1 each  single-cycle slave read and write strobes.
REQ-008 SHALL have port s1_writedata  in  32  slave write data.
REQ-009 SHALL have port s1_readdata  out  32  combinational slave read data.
REQ-010 SHALL have port s1_waitrequest  out  1  slave backpressure.
REQ-011 SHALL have port irq  out  1  interrupt request.
REQ-012 SHALL have ports m1_address (out, 32), m1_writedata (out, PIXEL_BITS) and m1_write (out, 1)  master write channel.
REQ-013 SHALL have port m1_waitrequest  in  1  master backpressure.
REQ-014 SHALL have ports op_start (out, 1) and op_code (out, 2)  shader-array command pulse and opcode.
REQ-015 SHALL have port op_arg  out  32  shader-array command argument.
REQ-016 SHALL have ports op_done and op_error  in  1 each  shader-array completion and fault.
REQ-017 SHALL have ports pixel_index (out, $clog2(NUM_SHADERS)) and pixel_in (in, PIXEL_BITS)  combinational pixel fetch.

Function
REQ-018 Any s1_write to 0x00-0x03 while not in ERROR and FIFO not full SHALL push {opcode=s1_address[1:0], arg=s1_writedata}.
REQ-019 s1_waitrequest SHALL be 1 exactly when s1_write targets 0x00-0x03 and the FIFO is full; no push occurs that cycle.
REQ-020 Push and pop in the same cycle SHALL leave the count unchanged; FIFO order is strict FIFO.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, BURST and ERROR.
REQ-022 IDLE with a non-empty FIFO SHALL pop the head on the next edge: opcode 2 enters BURST with index 0; other opcodes enter ISSUE.
REQ-023 ISSUE SHALL assert op_start for exactly one cycle with op_code/op_arg from the popped entry, then enter WAIT; op_code/op_arg SHALL stay stable until the command retires.
REQ-024 WAIT SHALL go to IDLE on op_done and to ERROR on op_error; op_error SHALL win if both are asserted together.
REQ-025 BURST SHALL drive m1_write=1, m1_address=arg+2*index, pixel_index=index and m1_writedata=pixel_in.
REQ-026 In BURST, index SHALL advance only on a cycle with m1_waitrequest=0; the write at index NUM_SHADERS-1 accepted SHALL return to IDLE, giving exactly NUM_SHADERS writes.
REQ-027 m1_address arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-028 Entering ERROR SHALL flush the FIFO; pushes in ERROR SHALL be silently dropped, with waitrequest 0.
REQ-029 Writing 0x0f with bit0=1 in ERROR SHALL return to IDLE; writes to 0x0f in any other state SHALL be ignored.
REQ-030 Register 0x0e (R/W, bit0 irq_en) SHALL gate irq.
REQ-031 irq_pend SHALL set when a command retires leaving FIFO empty and FSM going to IDLE, or on entry to ERROR.
REQ-032 irq SHALL equal irq_pend AND irq_en.
REQ-033 Reading 0x0f SHALL clear irq_pend; set SHALL win over a simultaneous clear.
REQ-034 Status 0x0f SHALL read as bit0 busy (state≠IDLE or FIFO non-empty), bit1 error, bit2 irq_pend, and bits[15:8] FIFO count.
REQ-035 Unmapped reads SHALL return 0.

Reset
REQ-036 On reset_n=0, the block SHALL be IDLE with FIFO empty, irq_en=0, irq_pend=0 and index=0.
REQ-037 On reset_n=0, outputs irq, op_start, op_code, op_arg, m1_write, m1_address, m1_writedata, pixel_index and s1_waitrequest SHALL be 0.
REQ-038 Reset asserted mid-WAIT or mid-BURST SHALL abort immediately with no further op_start or m1_write.

Configuration
REQ-039 With GPU_PERF_COUNTER_EN defined, register 0x0d SHALL read a 32-bit saturating count of busy cycles; writing any value to 0x0d SHALL zero it.
REQ-040 Without GPU_PERF_COUNTER_EN, 0x0d SHALL read 0, writes to it SHALL be ignored, and no counter SHALL be synthesised.

Verification
REQ-041 Write 0x01←0x5 from idle → op_start=1 for one cycle, op_code=1, op_arg=5; op_done → irq (if irq_en=1), status bit2=1, read 0x0f clears it.
REQ-042 NUM_SHADERS=4, write 0x02←0x1000, m1_waitrequest high on every other cycle → addresses 0x1000, 0x1002, 0x1004, 0x1006, each held until accepted, then IDLE.
REQ-043 CMD_DEPTH=4 with op_done held low, 6 pushes → pushes 1-5 accepted (1 popped), 6th sees s1_waitrequest=1 until op_done.
REQ-044 op_error and op_done in the same WAIT cycle with 2 entries queued → ERROR, count 0, irq_pend=1; write 0x0f←1 → IDLE.
REQ-045 Deassert reset_n at BURST index 2 → m1_write=0 next cycle; after release, status reads 0.
REQ-046 With GPU_PERF_COUNTER_EN, 0x0d value equals busy cycles of REQ-041; without the macro, it reads 0.
